// File: rtl/audio_sample_packet_decoder.sv
// audio_sample_packet_decoder
// Receive side of the HDMI 2-channel (layout 0) audio sample packet path.
// Extracts stereo L-PCM samples and their V/U/C/P bits from subpacket 0,
// checks IEC 60958 even parity, tracks the 192-frame channel status block
// using the B flag, and buffers samples in a show-ahead FIFO.
// Optional feature macro: AUDIO_DECODER_CHANNEL_STATUS_EN builds the
// channel status accumulators and output registers; without it those
// outputs are tied to zero while sync tracking still runs.
module audio_sample_packet_decoder #(
    parameter int FIFO_DEPTH        = 4,
    parameter int ERROR_COUNT_WIDTH = 16
) (
    input  logic                         clk_pixel,
    input  logic                         reset_n,
    input  logic                         packet_valid,
    input  logic [23:0]                  header,
    input  logic [3:0][55:0]             sub,
    output logic [1:0][23:0]             audio_sample_word,
    output logic [1:0]                   sample_valid_bit,
    output logic [1:0]                   sample_user_bit,
    output logic [1:0]                   sample_parity_error,
    output logic                         sample_valid,
    input  logic                         sample_ready,
    output logic [191:0]                 channel_status_left,
    output logic [191:0]                 channel_status_right,
    output logic                         channel_status_valid,
    output logic                         locked,
    output logic [ERROR_COUNT_WIDTH-1:0] sync_error_count,
    output logic [ERROR_COUNT_WIDTH-1:0] parity_error_count,
    output logic                         overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 54;  // {perr[1:0], u[1:0], v[1:0], right, left}

    typedef enum logic {HUNT, LOCKED} state_t;

    logic [55:0]   sp0;
    logic          accept;
    logic          b_flag;
    logic [1:0]    perr;
    logic [EW-1:0] entry_in;

    // Header bits and the other subpackets carry nothing this decoder needs.
    logic unused_bits;
    assign unused_bits = ^{sub[3:1], header[23:21], header[19:13], header[11:9]};

    assign sp0      = sub[0];
    assign accept   = packet_valid && (header[7:0] == 8'h02) && !header[12] && header[8];
    assign b_flag   = header[20];
    assign perr[0]  = ^{sp0[51:48], sp0[23:0]};
    assign perr[1]  = ^{sp0[55:52], sp0[47:24]};
    assign entry_in = {perr, sp0[53], sp0[49], sp0[52], sp0[48], sp0[47:0]};

    // ---------------- block sync FSM ----------------
    state_t     state_reg, state_next;
    logic [7:0] index_reg, index_next;
    logic       sync_err;

    // State and expected frame index register
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= HUNT;
            index_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
        end
    end

    // Next-state logic: B=1 marks frame 0; a misplaced B is a sync error
    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        sync_err   = 1'b0;
        if (accept) begin
            case (state_reg)
                HUNT: begin
                    if (b_flag) begin
                        state_next = LOCKED;
                        index_next = 8'd1;
                    end
                end
                LOCKED: begin
                    if (index_reg == 8'd0) begin
                        if (b_flag) begin
                            index_next = 8'd1;
                        end else begin
                            state_next = HUNT;
                            sync_err   = 1'b1;
                        end
                    end else if (b_flag) begin
                        // Early block start: this frame becomes frame 0
                        sync_err   = 1'b1;
                        index_next = 8'd1;
                    end else begin
                        index_next = (index_reg == 8'd191) ? 8'd0 : index_reg + 8'd1;
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    assign locked = (state_reg == LOCKED);

    // ---------------- error counters ----------------
    logic [ERROR_COUNT_WIDTH-1:0] sync_cnt_reg, parity_cnt_reg;

    // Saturating counters for sync errors and frames with any parity error
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            sync_cnt_reg   <= '0;
            parity_cnt_reg <= '0;
        end else begin
            if (sync_err && (sync_cnt_reg != '1))
                sync_cnt_reg <= sync_cnt_reg + 1'b1;
            if (accept && (|perr) && (parity_cnt_reg != '1))
                parity_cnt_reg <= parity_cnt_reg + 1'b1;
        end
    end

    assign sync_error_count   = sync_cnt_reg;
    assign parity_error_count = parity_cnt_reg;

    // ---------------- sample FIFO ----------------
    logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
    logic [EW-1:0] mem_reg [FIFO_DEPTH];
    logic [EW-1:0] head;
    logic          empty, full, pop, push;
    logic          overflow_reg;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop   = !empty && sample_ready;
    // A simultaneous pop frees the slot, so a full FIFO still takes the push
    assign push  = accept && (!full || pop);

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            // One FIFO slot, written when the write pointer addresses it
            always_ff @(posedge clk_pixel or negedge reset_n) begin
                if (!reset_n)
                    mem_reg[gi] <= '0;
                else if (push && (wr_ptr_reg[AW-1:0] == AW'(gi)))
                    mem_reg[gi] <= entry_in;
            end
        end
    endgenerate

    // Pointer update and sticky overflow on a dropped sample
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (accept && full && !pop)
                overflow_reg <= 1'b1;
        end
    end

    assign head                 = mem_reg[rd_ptr_reg[AW-1:0]];
    assign audio_sample_word[0] = head[23:0];
    assign audio_sample_word[1] = head[47:24];
    assign sample_valid_bit     = head[49:48];
    assign sample_user_bit      = head[51:50];
    assign sample_parity_error  = head[53:52];
    assign sample_valid         = !empty;
    assign overflow             = overflow_reg;

    // ---------------- channel status ----------------
`ifdef AUDIO_DECODER_CHANNEL_STATUS_EN
    logic         cs_wr_en;
    logic [7:0]   cs_wr_idx;
    logic [191:0] acc_left_reg, acc_right_reg, cs_left_reg, cs_right_reg;
    logic         block_done_reg, cs_valid_reg;

    // Every frame the FSM treats as part of a block writes its C bits; a
    // restarted block simply overwrites the stale bits before completing.
    assign cs_wr_en  = accept && (b_flag || (locked && (index_reg != 8'd0)));
    assign cs_wr_idx = b_flag ? 8'd0 : index_reg;

    // Accumulate C bits; publish the block one edge after frame 191 lands
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            acc_left_reg   <= '0;
            acc_right_reg  <= '0;
            cs_left_reg    <= '0;
            cs_right_reg   <= '0;
            block_done_reg <= 1'b0;
            cs_valid_reg   <= 1'b0;
        end else begin
            if (cs_wr_en) begin
                acc_left_reg[cs_wr_idx]  <= sp0[50];
                acc_right_reg[cs_wr_idx] <= sp0[54];
            end
            block_done_reg <= cs_wr_en && (cs_wr_idx == 8'd191);
            cs_valid_reg   <= block_done_reg;
            if (block_done_reg) begin
                cs_left_reg  <= acc_left_reg;
                cs_right_reg <= acc_right_reg;
            end
        end
    end

    assign channel_status_left  = cs_left_reg;
    assign channel_status_right = cs_right_reg;
    assign channel_status_valid = cs_valid_reg;
`else
    assign channel_status_left  = '0;
    assign channel_status_right = '0;
    assign channel_status_valid = 1'b0;
`endif

endmodule

// File: tb/tb_audio_sample_packet_decoder.sv
// tb_audio_sample_packet_decoder
// Directed stimulus with a scoreboard queue of expected FIFO entries.
// Channel status expectations follow AUDIO_DECODER_CHANNEL_STATUS_EN.
module tb_audio_sample_packet_decoder;

    localparam int DEPTH = 4;
    localparam int ECW   = 16;
`ifdef AUDIO_DECODER_CHANNEL_STATUS_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              packet_valid = 1'b0;
    logic [23:0]       header = '0;
    logic [3:0][55:0]  sub = '0;
    logic [1:0][23:0]  audio_sample_word;
    logic [1:0]        sample_valid_bit, sample_user_bit, sample_parity_error;
    logic              sample_valid;
    logic              sample_ready = 1'b0;
    logic [191:0]      channel_status_left, channel_status_right;
    logic              channel_status_valid, locked, overflow;
    logic [ECW-1:0]    sync_error_count, parity_error_count;

    audio_sample_packet_decoder #(.FIFO_DEPTH(DEPTH), .ERROR_COUNT_WIDTH(ECW)) dut (
        .clk_pixel(clk), .reset_n(reset_n), .packet_valid(packet_valid),
        .header(header), .sub(sub), .audio_sample_word(audio_sample_word),
        .sample_valid_bit(sample_valid_bit), .sample_user_bit(sample_user_bit),
        .sample_parity_error(sample_parity_error), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .channel_status_left(channel_status_left),
        .channel_status_right(channel_status_right),
        .channel_status_valid(channel_status_valid), .locked(locked),
        .sync_error_count(sync_error_count), .parity_error_count(parity_error_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_mism = 0;
    logic [53:0] q[$];
    logic        exp_ovf = 1'b0;
    int          exp_perr = 0;
    int          step_no = 0;
    int          cs_pulses = 0;
    int          pulse_step = -1;
    int          last_step;
    int          exp_sync;
    logic [191:0] exp_cs_left, exp_cs_right;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] mk_hdr(input logic [7:0] ptype, input logic layout,
                                           input logic sp0, input logic b);
        return {3'b000, b, 7'd0, layout, 3'b000, sp0, ptype};
    endfunction

    function automatic logic [55:0] mk_sub(input logic [23:0] l, input logic [23:0] r,
                                           input logic vl, input logic ul, input logic cl, input logic pl,
                                           input logic vr, input logic ur, input logic cr, input logic pr);
        return {pr, cr, ur, vr, pl, cl, ul, vl, r, l};
    endfunction

    // One clock cycle: check/pop the head, drive the packet, model the push
    task automatic step(input logic pv, input logic [23:0] h, input logic [55:0] s0);
        logic        acc;
        logic [1:0]  pe;
        logic [53:0] obs;
        check("sample_valid", sample_valid, q.size() != 0);
        if (sample_ready && q.size() != 0) begin
            obs = {sample_parity_error, sample_user_bit, sample_valid_bit,
                   audio_sample_word[1], audio_sample_word[0]};
            check("head_entry", obs, q[0]);
            void'(q.pop_front());
        end
        packet_valid = pv;
        header = h;
        sub[0] = s0;
        sub[1] = {24'($urandom), 32'($urandom)};
        sub[2] = {24'($urandom), 32'($urandom)};
        sub[3] = {24'($urandom), 32'($urandom)};
        acc = pv && (h[7:0] == 8'h02) && !h[12] && h[8];
        if (acc) begin
            pe[0] = ^{s0[51:48], s0[23:0]};
            pe[1] = ^{s0[55:52], s0[47:24]};
            if (pe != 2'b00) exp_perr++;
            if (q.size() < DEPTH)
                q.push_back({pe, s0[53], s0[49], s0[52], s0[48], s0[47:0]});
            else
                exp_ovf = 1'b1;
        end
        @(negedge clk);
        packet_valid = 1'b0;
        step_no++;
        check("overflow", overflow, exp_ovf);
        check("parity_error_count", parity_error_count, exp_perr);
        if (channel_status_valid) begin
            cs_pulses++;
            pulse_step = step_no;
        end
        $display("step %0d pv=%0b hdr=%06h valid=%0b locked=%0b sync=%0d perr=%0d ovf=%0b",
                 step_no, pv, h, sample_valid, locked, sync_error_count, parity_error_count, overflow);
    endtask

    task automatic idle();
        step(1'b0, 24'd0, 56'd0);
    endtask

    // Frame with correct parity on both channels
    task automatic good(input logic b, input logic cl, input logic cr);
        logic [23:0] l, r;
        logic [3:0]  vu;
        l  = 24'($urandom);
        r  = 24'($urandom);
        vu = 4'($urandom);
        step(1'b1, mk_hdr(8'h02, 1'b0, 1'b1, b),
             mk_sub(l, r, vu[0], vu[1], cl, ^{cl, vu[1], vu[0], l},
                    vu[2], vu[3], cr, ^{cr, vu[3], vu[2], r}));
    endtask

    task automatic do_reset();
        packet_valid = 1'b0;
        sample_ready = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_sample_valid", sample_valid, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_sync_count", sync_error_count, 0);
        check("rst_parity_count", parity_error_count, 0);
        check("rst_cs_valid", channel_status_valid, 1'b0);
        check("rst_cs_left", channel_status_left, 0);
        check("rst_word", {audio_sample_word[1], audio_sample_word[0]}, 0);
        reset_n = 1'b1;
        q.delete();
        exp_ovf = 1'b0;
        exp_perr = 0;
        cs_pulses = 0;
        pulse_step = -1;
    endtask

    initial begin
        exp_cs_left  = CS_EN ? {96{2'b10}} : 192'd0;
        exp_cs_right = CS_EN ? {192{1'b1}} : 192'd0;

        // ---- full 192-frame block ----
        do_reset();
        sample_ready = 1'b1;
        for (int i = 0; i < 192; i++) begin
            good(i == 0, i[0], 1'b1);
            if (i == 0) check("lock_after_frame0", locked, 1'b1);
        end
        last_step = step_no;
        check("cs_no_early_pulse", cs_pulses, 0);
        idle();
        idle();
        idle();
        check("cs_pulse_count", cs_pulses, CS_EN ? 1 : 0);
        check("cs_pulse_cycle", pulse_step, CS_EN ? last_step + 1 : -1);
        check("cs_left", channel_status_left, exp_cs_left);
        check("cs_right", channel_status_right, exp_cs_right);
        check("blk_sync_count", sync_error_count, 0);
        check("blk_locked", locked, 1'b1);

        // ---- parity errors ----
        do_reset();
        sample_ready = 1'b1;
        step(1'b1, mk_hdr(8'h02, 1'b0, 1'b1, 1'b0),
             mk_sub(24'h000001, 24'h000000, 0, 0, 0, 0, 0, 0, 0, 0));
        check("perr_left_valid", sample_valid, 1'b1);
        check("perr_left_bits", sample_parity_error, 2'b01);
        check("perr_left_word", audio_sample_word[0], 24'h000001);
        check("perr_left_count", parity_error_count, 1);
        step(1'b1, mk_hdr(8'h02, 1'b0, 1'b1, 1'b0),
             mk_sub(24'h000000, 24'h000003, 0, 0, 0, 0, 1, 0, 0, 0));
        check("perr_right_bits", sample_parity_error, 2'b10);
        step(1'b1, mk_hdr(8'h02, 1'b0, 1'b1, 1'b0),
             mk_sub(24'h000010, 24'h000100, 0, 0, 0, 0, 0, 0, 0, 0));
        check("perr_both_bits", sample_parity_error, 2'b11);
        check("perr_frame_count", parity_error_count, 3);
        idle();
        idle();

        // ---- early B=1 at index 50, then B=0 at index 0 ----
        do_reset();
        sample_ready = 1'b1;
        good(1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 50; i++) good(1'b0, 1'b0, 1'b0);
        check("pre_early_sync_count", sync_error_count, 0);
        good(1'b1, 1'b0, 1'b1);
        check("early_sync_count", sync_error_count, 1);
        check("early_locked", locked, 1'b1);
        for (int i = 1; i < 192; i++) good(1'b0, i[0], 1'b1);
        last_step = step_no;
        check("early_no_pulse", cs_pulses, 0);
        idle();
        check("early_pulse_cycle", pulse_step, CS_EN ? last_step + 1 : -1);
        check("early_cs_left", channel_status_left, exp_cs_left);
        good(1'b0, 1'b0, 1'b0);
        check("idx0_b0_locked", locked, 1'b0);
        check("idx0_b0_sync_count", sync_error_count, 2);
        good(1'b0, 1'b0, 1'b0);
        check("hunt_b0_sync_count", sync_error_count, 2);
        check("hunt_b0_locked", locked, 1'b0);
        good(1'b1, 1'b0, 1'b0);
        check("relock", locked, 1'b1);
        idle();

        // ---- FIFO overflow and push+pop while full ----
        do_reset();
        sample_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) good(1'b0, 1'b0, 1'b0);
        check("ovf_set", overflow, 1'b1);
        sample_ready = 1'b1;
        good(1'b0, 1'b0, 1'b0);
        sample_ready = 1'b0;
        good(1'b0, 1'b0, 1'b0);
        idle();
        check("ovf_sticky", overflow, 1'b1);
        sample_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) idle();
        check("drained", sample_valid, 1'b0);
        good(1'b0, 1'b0, 1'b0);
        idle();
        idle();

        // ---- ignored packets ----
        do_reset();
        sample_ready = 1'b1;
        good(1'b1, 1'b0, 1'b0);
        step(1'b1, mk_hdr(8'h01, 1'b0, 1'b1, 1'b1), 56'h0);
        step(1'b1, mk_hdr(8'h02, 1'b1, 1'b1, 1'b1), 56'h0);
        step(1'b1, mk_hdr(8'h02, 1'b0, 1'b0, 1'b1), 56'h0);
        step(1'b0, mk_hdr(8'h02, 1'b0, 1'b1, 1'b1), 56'h0);
        step(1'b1, mk_hdr(8'h01, 1'b0, 1'b1, 1'b0), 56'h0);
        check("ign_sync_count", sync_error_count, 0);
        for (int i = 1; i < 192; i++) good(1'b0, 1'b0, 1'b0);
        good(1'b1, 1'b0, 1'b0);
        check("ign_idx_sync_count", sync_error_count, 0);
        check("ign_locked", locked, 1'b1);
        check("ign_pulse_count", cs_pulses, CS_EN ? 1 : 0);
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

endmodule
